// File: rtl/clint_arb_pkg.sv
// ---------------------------------------------------------------------------
// clint_arb_pkg
// Shared types and helpers for the CLINT BRAM arbiter.
//   DATA_W / BE_W  : CLINT control BRAM word width and byte-enable width.
//   MAX_REQ        : largest supported requester count.
//   MAX_ADDR_W     : widest supported byte address.
//   req_t          : one requester's command (addr, we, wdata).
//   unpack_req()   : extracts requester slice i from the packed port vectors.
// ---------------------------------------------------------------------------
package clint_arb_pkg;

    localparam int DATA_W     = 64;
    localparam int BE_W       = 8;
    localparam int MAX_REQ    = 8;
    localparam int MAX_ADDR_W = 32;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [BE_W-1:0]       we;
        logic [DATA_W-1:0]     wdata;
    } req_t;

    // The packed vectors are zero-extended to the maximum sizes by the caller,
    // so one function serves every NUM_REQ / ADDR_W combination.
    function automatic req_t unpack_req(
        input logic [MAX_REQ*MAX_ADDR_W-1:0] addr_v,
        input logic [MAX_REQ*BE_W-1:0]       we_v,
        input logic [MAX_REQ*DATA_W-1:0]     wdata_v,
        input int                            addr_w,
        input int                            idx
    );
        req_t r;
        r.addr = '0;
        for (int b = 0; b < MAX_ADDR_W; b++) begin
            if (b < addr_w) r.addr[b] = addr_v[idx*addr_w + b];
        end
        r.we    = we_v[idx*BE_W +: BE_W];
        r.wdata = wdata_v[idx*DATA_W +: DATA_W];
        return r;
    endfunction

endpackage

// File: rtl/clint_bram_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin grant (purely combinational).
//   req     : request mask.
//   ptr     : highest-priority index; the search wraps from N-1 to 0.
//   gnt     : one-hot grant (all zero when no request).
//   gnt_idx : encoded index of the granted requester (0 when none).
//   any     : at least one request granted.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search loop, so no
        // path through the block leaves a value unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clint_bram_arbiter.sv
// ---------------------------------------------------------------------------
// clint_bram_arbiter
// Round-robin sharing of the single 64-bit CLINT control BRAM port
// (READ_LATENCY 1) between NUM_REQ requesters. Grant and BRAM drive are
// combinational; the response strobe is registered one cycle after the
// handshake and read data is passed straight through from the BRAM.
//
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset.
//   req_valid/req_ready  : per-requester request handshake (ready is the grant).
//   req_addr/we/wdata    : packed request fields, requester i in slice i.
//   req_lock             : (CLINT_ARB_LOCK_EN only) lock request per requester.
//   rsp_valid            : one-hot response strobe.
//   rsp_rdata            : shared read data, meaningful only with rsp_valid.
//   bram_*               : CLINT BRAM port.
//
// Build option: define CLINT_ARB_LOCK_EN to add req_lock. A handshake with
// its lock bit set pins the grant to that requester until it completes a
// handshake with the lock bit clear.
// ---------------------------------------------------------------------------
module clint_bram_arbiter
    import clint_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*BE_W-1:0]     req_we,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
`ifdef CLINT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          req_lock,
`endif
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           bram_addr,
    output logic                        bram_en,
    output logic [BE_W-1:0]             bram_we,
    output logic [DATA_W-1:0]           bram_wrdata,
    input  logic [DATA_W-1:0]           bram_rddata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]              rr_ptr;
    logic [IDX_W-1:0]              ptr_next;
    logic [NUM_REQ-1:0]            arb_mask;
    logic [NUM_REQ-1:0]            gnt;
    logic [IDX_W-1:0]              gnt_idx;
    logic                          gnt_any;
    logic                          hs;
    logic                          ptr_upd;
    logic [MAX_REQ*MAX_ADDR_W-1:0] addr_ext;
    logic [MAX_REQ*BE_W-1:0]       we_ext;
    logic [MAX_REQ*DATA_W-1:0]     wdata_ext;
    req_t                          sel;

    // -------------------------------------------------------------------
    // Lock handling: while locked, only the owner is visible to the arbiter.
    // A lock-setting handshake leaves the pointer alone; any handshake with
    // the lock bit clear (plain or releasing) advances it.
    // -------------------------------------------------------------------
`ifdef CLINT_ARB_LOCK_EN
    logic             locked;
    logic [IDX_W-1:0] lock_idx;
    logic             gnt_lock;

    assign arb_mask = locked ? (req_valid & (NUM_REQ'(1) << lock_idx)) : req_valid;
    assign gnt_lock = |(req_lock & gnt);
    assign ptr_upd  = hs && !gnt_lock;

    // While locked only the owner can be granted, so the lock flag simply
    // follows the lock bit of each handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (hs) begin
            locked <= gnt_lock;
            if (gnt_lock) lock_idx <= gnt_idx;
        end
    end
`else
    assign arb_mask = req_valid;
    assign ptr_upd  = hs;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (arb_mask),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // No access may reach the BRAM while reset is asserted.
    assign hs        = gnt_any && rstn;
    assign req_ready = hs ? gnt : '0;

    always_comb begin
        addr_ext  = '0;
        we_ext    = '0;
        wdata_ext = '0;
        addr_ext[NUM_REQ*ADDR_W-1:0]  = req_addr;
        we_ext[NUM_REQ*BE_W-1:0]      = req_we;
        wdata_ext[NUM_REQ*DATA_W-1:0] = req_wdata;
    end

    assign sel = unpack_req(addr_ext, we_ext, wdata_ext, ADDR_W, int'(gnt_idx));

    assign bram_en     = hs;
    assign bram_addr   = hs ? sel.addr[ADDR_W-1:0] : '0;
    assign bram_we     = hs ? sel.we : '0;
    assign bram_wrdata = hs ? sel.wdata : '0;
    assign rsp_rdata   = bram_rddata;

    // (granted + 1) mod NUM_REQ; collapses to 0 when NUM_REQ == 1.
    always_comb begin
        int nxt;
        nxt = int'(gnt_idx) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        ptr_next = IDX_W'(nxt);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= req_ready;
            if (ptr_upd) rr_ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_clint_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_clint_bram_arbiter
// Directed scenarios followed by randomized traffic. A reference model
// (priority search from a pointer, lock owner, word memory) predicts each
// cycle's grant; every predicted handshake pushes an expected response into
// a scoreboard queue that an independent monitor drains.
// ---------------------------------------------------------------------------
module tb_clint_bram_arbiter;

    localparam int NR = 2;
    localparam int AW = 16;
`ifdef CLINT_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*8-1:0]   req_we;
    logic [NR*64-1:0]  req_wdata;
    logic [63:0]       rsp_rdata, bram_wrdata, bram_rddata;
    logic [AW-1:0]     bram_addr;
    logic              bram_en;
    logic [7:0]        bram_we;
`ifdef CLINT_ARB_LOCK_EN
    logic [NR-1:0]     req_lock;
`endif

    always #5 clk = ~clk;

    clint_bram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_wdata   (req_wdata),
`ifdef CLINT_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .bram_addr   (bram_addr),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_wrdata (bram_wrdata),
        .bram_rddata (bram_rddata)
    );

    function automatic logic [63:0] init_word(input logic [12:0] wi);
        return {32'hC1A7_0000, 19'h0, wi};
    endfunction

    // CLINT BRAM stand-in: read-first, one cycle latency.
    logic [63:0] bram_mem [logic [12:0]];
    logic [12:0] bw;
    logic [63:0] bcur;
    always @(posedge clk) begin
        if (bram_en) begin
            bw   = bram_addr[15:3];
            bcur = bram_mem.exists(bw) ? bram_mem[bw] : init_word(bw);
            bram_rddata <= bcur;
            for (int b = 0; b < 8; b++)
                if (bram_we[b]) bcur[b*8 +: 8] = bram_wrdata[b*8 +: 8];
            bram_mem[bw] = bcur;
        end
    end

    // Requester stimulus state.
    logic          pend [NR];
    logic [AW-1:0] a    [NR];
    logic [7:0]    w    [NR];
    logic [63:0]   d    [NR];
    logic          lk   [NR];
    bit            random_mode = 1'b0;

    // Reference model.
    logic [63:0] ref_mem [logic [12:0]];
    int          m_ptr = 0;
    bit          m_locked = 1'b0;
    int          m_lock_idx = 0;

    typedef struct {
        int          due;
        int          idx;
        bit          rd;
        logic [63:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = pend[i];
            req_addr[i*AW +: AW]  = a[i];
            req_we[i*8 +: 8]      = w[i];
            req_wdata[i*64 +: 64] = d[i];
`ifdef CLINT_ARB_LOCK_EN
            req_lock[i]           = lk[i];
`endif
        end
    endtask

    function automatic int model_grant();
        if (!rstn) return -1;
        if (m_locked) return pend[m_lock_idx] ? m_lock_idx : -1;
        for (int off = 0; off < NR; off++) begin
            int i;
            i = (m_ptr + off) % NR;
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic gen();
        int base [3];
        base[0] = 'h0000;
        base[1] = 'h4000;
        base[2] = 'hBFE0;
        for (int i = 0; i < NR; i++) begin
            bit owner;
            owner = m_locked && (m_lock_idx == i);
            if (!pend[i]) begin
                if (owner || $urandom_range(99) < 60) begin
                    pend[i] = 1'b1;
                    a[i]    = AW'(base[$urandom_range(0, 2)] + 8 * $urandom_range(0, 3));
                    w[i]    = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                    d[i]    = {$urandom, $urandom};
                    lk[i]   = LOCK && !owner && ($urandom_range(9) == 0);
                end
            end else if (!owner && $urandom_range(19) == 0) begin
                pend[i] = 1'b0;
            end
        end
    endtask

    // One clock: compare grant/BRAM drive at negedge against the model,
    // record the predicted handshake, then refresh stimulus after the edge.
    task automatic step(output int g);
        logic [12:0] wi;
        logic [63:0] cur;
        @(negedge clk);
        g = model_grant();
        check("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        check("bram_en", 64'(bram_en), 64'(g >= 0));
        if (g >= 0) begin
            check("bram_addr", 64'(bram_addr), 64'(a[g]));
            check("bram_we", 64'(bram_we), 64'(w[g]));
            check("bram_wrdata", bram_wrdata, d[g]);
            wi  = a[g][15:3];
            cur = ref_mem.exists(wi) ? ref_mem[wi] : init_word(wi);
            sbq.push_back('{due: cyc + 1, idx: g, rd: (w[g] == 8'h00), data: cur});
            for (int b = 0; b < 8; b++)
                if (w[g][b]) cur[b*8 +: 8] = d[g][b*8 +: 8];
            ref_mem[wi] = cur;
            if (LOCK && lk[g]) begin
                m_locked   = 1'b1;
                m_lock_idx = g;
            end else begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % NR;
            end
            pend[g] = 1'b0;
            lk[g]   = 1'b0;
        end else begin
            check("bram_addr_idle", 64'(bram_addr), 64'd0);
            check("bram_we_idle", 64'(bram_we), 64'd0);
        end
        @(posedge clk);
        #1;
        if (random_mode) gen();
        drive();
    endtask

    // Response monitor, decoupled from stimulus.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    e = sbq.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'd1 << e.idx);
                    if (e.rd) check("rsp_rdata", rsp_rdata, e.data);
                end else begin
                    check("rsp_idle", 64'(rsp_valid), 64'd0);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] ad, input logic [7:0] we,
                           input logic [63:0] dat, input logic lock);
        pend[i] = 1'b1;
        a[i]    = ad;
        w[i]    = we;
        d[i]    = dat;
        lk[i]   = lock;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_bram_en", 64'(bram_en), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        sbq.delete();
        m_ptr    = 0;
        m_locked = 1'b0;
    endtask

    int g;
    int seq [6];

    initial begin
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; a[i] = '0; w[i] = '0; d[i] = '0; lk[i] = 1'b0;
        end
        drive();

        // Reset with nothing requested.
        #2;
        do_reset();
        step(g);
        step(g);
        rstn = 1'b1;
        step(g);

        // Single read from requester 1 at mtime.
        set_req(1, 16'hBFF8, 8'h00, 64'h0, 1'b0);
        drive();
        step(g);
        check("single_read_grant", 64'(g), 64'd1);
        step(g);

        // Both requesters continuously valid: strict alternation.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i]) set_req(i, AW'(16'h4000 + 8 * k), 8'h00, 64'h0, 1'b0);
            drive();
            step(seq[k]);
        end
        for (int k = 0; k < 6; k++) check("alternate", 64'(seq[k]), 64'(k % 2));
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drive();
        step(g);

        // Write msip then read it back, back-to-back.
        set_req(0, 16'h0000, 8'hFF, 64'h1, 1'b0);
        drive();
        step(g);
        set_req(0, 16'h0000, 8'h00, 64'h0, 1'b0);
        drive();
        step(g);
        step(g);

        // Requester 1 waits behind 0, then withdraws.
        set_req(1, 16'h0008, 8'h00, 64'h0, 1'b0);
        drive();
        step(g);
        set_req(0, 16'h0010, 8'h00, 64'h0, 1'b0);
        set_req(1, 16'h0018, 8'h00, 64'h0, 1'b0);
        drive();
        step(g);
        check("waiting_grant", 64'(g), 64'd0);
        pend[1] = 1'b0;
        set_req(0, 16'h0020, 8'h0F, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        drive();
        step(g);
        check("after_withdraw", 64'(g), 64'd0);
        step(g);

`ifdef CLINT_ARB_LOCK_EN
        // Locked write pair from requester 0 holds off requester 1.
        set_req(1, 16'h0028, 8'h00, 64'h0, 1'b0);
        drive();
        step(g);
        set_req(0, 16'h4000, 8'hFF, 64'h1111_2222_3333_4444, 1'b1);
        set_req(1, 16'h4000, 8'h00, 64'h0, 1'b0);
        drive();
        step(seq[0]);
        set_req(0, 16'h4004, 8'hF0, 64'h5555_6666_7777_8888, 1'b0);
        drive();
        step(seq[1]);
        step(seq[2]);
        check("lock_c0", 64'(seq[0]), 64'd0);
        check("lock_c1", 64'(seq[1]), 64'd0);
        check("lock_c2", 64'(seq[2]), 64'd1);
        step(g);
`endif

        // Randomized traffic with a reset in the middle.
        random_mode = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                do_reset();
                step(g);
                step(g);
                rstn = 1'b1;
            end
            step(g);
        end

        random_mode = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0;
            lk[i]   = 1'b0;
        end
        drive();
        step(g);
        step(g);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
